// File: rtl/usb_txn_ctrl_if.sv
// Bundle of the host request/result signals plus the transmit and receive
// pipeline handshakes seen by the transaction controller.
interface usb_txn_ctrl_if;
  // Host-side request and result
  logic        txn_start;
  logic        txn_is_in;
  logic [6:0]  txn_addr;
  logic [3:0]  txn_endp;
  logic [63:0] txn_wdata;
  logic        txn_done;
  logic        txn_success;
  logic [63:0] txn_rdata;
  // Transmit pipeline
  logic [3:0]  out_pid;
  logic [3:0]  out_endp;
  logic [6:0]  out_addr;
  logic [63:0] out_data;
  logic        out_pkttype;
  logic        out_pktready;
  logic        out_down_ready;
  logic        out_sending;
  logic        writing;
  // Receive pipeline
  logic [63:0] in_data;
  logic        in_pktready;
  logic        in_error;
  logic        in_ack;
  logic        in_nak;

  // Environment side: host registers plus both packet pipelines
  modport master (
    output txn_start, txn_is_in, txn_addr, txn_endp, txn_wdata,
    output out_down_ready, out_sending,
    output in_data, in_pktready, in_error, in_ack, in_nak,
    input  txn_done, txn_success, txn_rdata,
    input  out_pid, out_endp, out_addr, out_data, out_pkttype, out_pktready,
    input  writing
  );

  // Controller side
  modport slave (
    input  txn_start, txn_is_in, txn_addr, txn_endp, txn_wdata,
    input  out_down_ready, out_sending,
    input  in_data, in_pktready, in_error, in_ack, in_nak,
    output txn_done, txn_success, txn_rdata,
    output out_pid, out_endp, out_addr, out_data, out_pkttype, out_pktready,
    output writing
  );
endinterface

// File: rtl/usb_txn_ctrl.sv
// USB transaction controller: sequences token/data/handshake packets for one
// OUT or IN request, retries failed attempts and reports a single result.
module usb_txn_ctrl #(
  parameter int MAX_RETRY = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst_L,
  usb_txn_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_TOK, S_TX_DATA, S_RX_WAIT, S_TX_HS, S_DONE
  } state_t;

  // Progress of one packet send: request, wait for bus start, wait for bus end
  typedef enum logic [1:0] {PH_REQ, PH_RISE, PH_FALL} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [3:0]      attempt_q, attempt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            succ_q, succ_d;
  logic            is_in_q, is_in_d;
  logic [6:0]      addr_q, addr_d;
  logic [3:0]      endp_q, endp_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [63:0]     rdata_q, rdata_d;
  logic [3:0]      pid_q, pid_d;
  logic            pkttype_q, pkttype_d;
  logic [6:0]      oaddr_q, oaddr_d;
  logic [3:0]      oendp_q, oendp_d;
  logic [63:0]     odata_q, odata_d;
  logic            fail;
  logic            send_end;
  logic            tmo_hit;

  // State and datapath registers
  // NOTE: asynchronous reset in the sensitivity list, and only non-blocking
  // assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_REQ;
      attempt_q <= '0;
      tmo_q     <= '0;
      succ_q    <= 1'b0;
      is_in_q   <= 1'b0;
      addr_q    <= '0;
      endp_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      pid_q     <= '0;
      pkttype_q <= 1'b0;
      oaddr_q   <= '0;
      oendp_q   <= '0;
      odata_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      attempt_q <= attempt_d;
      tmo_q     <= tmo_d;
      succ_q    <= succ_d;
      is_in_q   <= is_in_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      pid_q     <= pid_d;
      pkttype_q <= pkttype_d;
      oaddr_q   <= oaddr_d;
      oendp_q   <= oendp_d;
      odata_q   <= odata_d;
    end
  end

  assign send_end = (phase_q == PH_FALL) && !bus.out_sending;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

  // Next-state logic: transitions, retry decision and packet field loading
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    attempt_d = attempt_q;
    tmo_d     = tmo_q;
    succ_d    = succ_q;
    is_in_d   = is_in_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    pid_d     = pid_q;
    pkttype_d = pkttype_q;
    oaddr_d   = oaddr_q;
    oendp_d   = oendp_q;
    odata_d   = odata_q;
    fail      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.txn_start) begin
          is_in_d   = bus.txn_is_in;
          addr_d    = bus.txn_addr;
          endp_d    = bus.txn_endp;
          wdata_d   = bus.txn_wdata;
          rdata_d   = '0;
          succ_d    = 1'b0;
          attempt_d = 4'd1;
          state_d   = S_TX_TOK;
        end
      end
      S_TX_TOK, S_TX_DATA, S_TX_HS: begin
        case (phase_q)
          PH_REQ:  if (bus.out_down_ready) phase_d = PH_RISE;
          PH_RISE: if (bus.out_sending)    phase_d = PH_FALL;
          default: ;
        endcase
        if (send_end) begin
          case (state_q)
            S_TX_TOK:  state_d = is_in_q ? S_RX_WAIT : S_TX_DATA;
            S_TX_DATA: state_d = S_RX_WAIT;
            default: begin
              if (succ_q) state_d = S_DONE;
              else        fail    = 1'b1;
            end
          endcase
        end
      end
      S_RX_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (!is_in_q) begin
          // Data packets are meaningless after an OUT; they do not mask errors
          if (bus.in_ack) begin
            succ_d  = 1'b1;
            state_d = S_DONE;
          end else if (bus.in_nak || bus.in_error || tmo_hit) begin
            fail = 1'b1;
          end
        end else begin
          // An ACK is meaningless after an IN token and is skipped
          if (bus.in_nak) begin
            fail = 1'b1;
          end else if (bus.in_pktready && !bus.in_error) begin
            rdata_d = bus.in_data;
            succ_d  = 1'b1;
            state_d = S_TX_HS;
          end else if (bus.in_error) begin
            succ_d  = 1'b0;
            state_d = S_TX_HS;
          end else if (tmo_hit) begin
            fail = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      if (attempt_q == 4'(MAX_RETRY)) begin
        succ_d  = 1'b0;
        state_d = S_DONE;
      end else begin
        attempt_d = attempt_q + 4'd1;
        state_d   = S_TX_TOK;
      end
    end

    // Entry actions; packet fields change only when a new send begins
    if (state_d != state_q) begin
      case (state_d)
        S_TX_TOK: begin
          phase_d   = PH_REQ;
          pid_d     = is_in_d ? PID_IN : PID_OUT;
          pkttype_d = 1'b0;
          oaddr_d   = addr_d;
          oendp_d   = endp_d;
        end
        S_TX_DATA: begin
          phase_d   = PH_REQ;
          pid_d     = PID_DATA0;
          pkttype_d = 1'b1;
          odata_d   = wdata_d;
        end
        S_TX_HS: begin
          phase_d   = PH_REQ;
          pid_d     = succ_d ? PID_ACK : PID_NAK;
          pkttype_d = 1'b0;
        end
        S_RX_WAIT: tmo_d = '0;
        default: ;
      endcase
    end
  end

  // Output decode from the current state and held registers
  always_comb begin
    bus.writing      = (state_q == S_TX_TOK) || (state_q == S_TX_DATA) || (state_q == S_TX_HS);
    bus.out_pktready = bus.writing && (phase_q == PH_REQ);
    bus.txn_done     = (state_q == S_DONE);
    bus.txn_success  = (state_q == S_DONE) && succ_q;
    bus.txn_rdata    = rdata_q;
    bus.out_pid      = pid_q;
    bus.out_pkttype  = pkttype_q;
    bus.out_addr     = oaddr_q;
    bus.out_endp     = oendp_q;
    bus.out_data     = odata_q;
  end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Self-checking bench for usb_txn_ctrl: emulates both packet pipelines,
// scripts the device reply per attempt and compares against a transaction model.
module tb_usb_txn_ctrl;

  localparam int MAX_RETRY = 8;
  localparam int TIMEOUT   = 255;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum int {R_NONE, R_ACK, R_NAK, R_DATA, R_ERR} resp_e;

  typedef struct packed {
    logic [3:0]  pid;
    logic        pkttype;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  always #5 clk = ~clk;

  usb_txn_ctrl_if bus();

  usb_txn_ctrl #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-attempt device reply script
  resp_e       sc_kind [MAX_RETRY];
  int          sc_dly  [MAX_RETRY];
  logic [63:0] sc_data [MAX_RETRY];

  // Pipeline emulation state
  int   tx_ph, bp_cnt, s_gap, s_len;
  int   bp_once = -1;
  pkt_t snap, cur;
  int   bp_bad;
  pkt_t log_q[$];
  bit   wr_prev, rx_act, busy, prev_done, done_succ;
  int   rx_idx, att, gap_cnt, done_cnt, wide_done;

  function automatic pkt_t norm(input logic [3:0] pid, input logic pt, input logic [6:0] a,
                                input logic [3:0] e, input logic [63:0] d);
    pkt_t p;
    p.pid = pid; p.pkttype = pt; p.addr = a; p.endp = e; p.data = d;
    if (pid == PID_OUT || pid == PID_IN) p.data = '0;
    else if (pid == PID_DATA0) begin p.addr = '0; p.endp = '0; end
    else begin p.addr = '0; p.endp = '0; p.data = '0; end
    return p;
  endfunction

  // Transmit/receive pipeline emulation, evaluated on every falling edge
  initial begin
    bus.out_down_ready = 1'b0; bus.out_sending = 1'b0;
    bus.in_data = '0; bus.in_pktready = 1'b0; bus.in_error = 1'b0;
    bus.in_ack = 1'b0; bus.in_nak = 1'b0;
    tx_ph = 0; rx_act = 0; wr_prev = 0; prev_done = 0; busy = 0;
    done_cnt = 0; wide_done = 0; gap_cnt = 0; att = 0; bp_bad = 0;
    forever begin
      @(negedge clk);
      bus.in_pktready = 1'b0; bus.in_error = 1'b0; bus.in_ack = 1'b0; bus.in_nak = 1'b0;
      if (!rst_L) begin
        bus.out_down_ready = 1'b0; bus.out_sending = 1'b0;
        tx_ph = 0; rx_act = 0; wr_prev = 0; prev_done = 0;
        continue;
      end
      if (bus.txn_done) begin
        if (prev_done) wide_done++;
        else begin done_cnt++; done_succ = bus.txn_success; end
        busy = 0;
      end
      prev_done = bus.txn_done;
      if (busy && !bus.writing && !bus.txn_done) gap_cnt++;

      // Device reply, timed from the first receive-wait cycle
      if (wr_prev && !bus.writing && !bus.txn_done) begin rx_act = 1; rx_idx = 0; end
      wr_prev = bus.writing;
      if (rx_act) begin
        if (att >= MAX_RETRY) rx_act = 0;
        else if (sc_kind[att] != R_NONE && rx_idx == sc_dly[att]) begin
          case (sc_kind[att])
            R_ACK:  bus.in_ack = 1'b1;
            R_NAK:  bus.in_nak = 1'b1;
            R_ERR:  bus.in_error = 1'b1;
            R_DATA: begin bus.in_pktready = 1'b1; bus.in_data = sc_data[att]; end
            default: ;
          endcase
          rx_act = 0; att++;
        end else begin
          rx_idx++;
          if (rx_idx >= TIMEOUT) begin rx_act = 0; att++; end
        end
      end

      // Packet acceptance with optional back-pressure, then a bus burst
      cur = {bus.out_pid, bus.out_pkttype, bus.out_addr, bus.out_endp, bus.out_data};
      if (tx_ph == 0 && bus.out_pktready) begin
        snap = cur;
        bp_cnt = (bp_once >= 0) ? bp_once : int'($urandom_range(0, 3));
        bp_once = -1;
        tx_ph = 1;
      end
      if (tx_ph == 1) begin
        if (!bus.out_pktready || cur !== snap) bp_bad++;
        if (bp_cnt == 0) begin
          bus.out_down_ready = 1'b1;
          log_q.push_back(norm(cur.pid, cur.pkttype, cur.addr, cur.endp, cur.data));
          tx_ph = 2;
        end else bp_cnt--;
      end else if (tx_ph == 2) begin
        bus.out_down_ready = 1'b0;
        if (bus.out_pktready || cur !== snap) bp_bad++;
        s_gap = $urandom_range(0, 2);
        tx_ph = 3;
      end else if (tx_ph == 3) begin
        if (cur !== snap) bp_bad++;
        if (s_gap == 0) begin
          bus.out_sending = 1'b1; s_len = $urandom_range(1, 6); tx_ph = 4;
        end else s_gap--;
      end else if (tx_ph == 4) begin
        if (cur !== snap) bp_bad++;
        s_len--;
        if (s_len == 0) begin bus.out_sending = 1'b0; tx_ph = 0; end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fields"},
          128'({bus.out_pid, bus.out_endp, bus.out_addr, bus.out_data, bus.out_pkttype,
                bus.out_pktready, bus.writing, bus.txn_done, bus.txn_success}), 128'(0));
    check({tag, "_rdata"}, 128'(bus.txn_rdata), 128'(0));
  endtask

  task automatic start_txn(input bit is_in, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] w);
    @(negedge clk); #1;
    bus.txn_start = 1'b1; bus.txn_is_in = is_in;
    bus.txn_addr = a; bus.txn_endp = e; bus.txn_wdata = w;
    busy = 1;
    @(negedge clk); #1;
    bus.txn_start = 1'b0;
    // Scramble request inputs: the controller must have captured them already
    bus.txn_is_in = 1'($urandom); bus.txn_addr = 7'($urandom);
    bus.txn_endp = 4'($urandom); bus.txn_wdata = {$urandom, $urandom};
  endtask

  task automatic run_txn(input string tag, input bit is_in, input logic [6:0] a,
                         input logic [3:0] e, input logic [63:0] w, input bit noise);
    pkt_t        exp_q[$];
    bit          es;
    logic [63:0] er;
    int          eg, d0, n;
    bit          seen;
    // Reference: walk the retry rules over the scripted replies
    es = 0; er = '0; eg = 0;
    for (int k = 0; k < MAX_RETRY; k++) begin
      exp_q.push_back(norm(is_in ? PID_IN : PID_OUT, 1'b0, a, e, '0));
      if (!is_in) exp_q.push_back(norm(PID_DATA0, 1'b1, '0, '0, w));
      eg += (sc_kind[k] == R_NONE) ? TIMEOUT : sc_dly[k] + 1;
      if (!is_in && sc_kind[k] == R_ACK) begin es = 1; break; end
      if (is_in && sc_kind[k] == R_DATA) begin
        er = sc_data[k]; exp_q.push_back(norm(PID_ACK, 1'b0, '0, '0, '0)); es = 1; break;
      end
      if (is_in && sc_kind[k] == R_ERR) exp_q.push_back(norm(PID_NAK, 1'b0, '0, '0, '0));
    end

    log_q.delete(); att = 0; gap_cnt = 0; bp_bad = 0; wide_done = 0;
    d0 = done_cnt;
    start_txn(is_in, a, e, w);
    if (noise) begin
      repeat (20) @(negedge clk);
      #1;
      bus.txn_start = 1'b1; bus.txn_is_in = ~is_in; bus.txn_addr = ~a; bus.txn_endp = ~e;
      @(negedge clk); #1;
      bus.txn_start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #2;
      if (done_cnt != d0) begin seen = 1; break; end
    end
    check({tag, "_done_seen"}, 128'(seen), 128'(1));
    if (!seen) begin
      @(negedge clk); #1 rst_L = 1'b0; busy = 0;
      repeat (2) @(negedge clk);
      #1 rst_L = 1'b1;
      return;
    end
    @(negedge clk); #2;
    check({tag, "_done_once"}, 128'(done_cnt - d0), 128'(1));
    check({tag, "_done_width"}, 128'(wide_done), 128'(0));
    check({tag, "_success"}, 128'(done_succ), 128'(es));
    check({tag, "_rdata"}, 128'(bus.txn_rdata), 128'(er));
    check({tag, "_rx_wait_cycles"}, 128'(gap_cnt), 128'(eg));
    check({tag, "_tx_handshake"}, 128'(bp_bad), 128'(0));
    check({tag, "_pkt_count"}, 128'(log_q.size()), 128'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pkt%0d", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
  endtask

  task automatic clear_script();
    for (int k = 0; k < MAX_RETRY; k++) begin
      sc_kind[k] = R_NONE; sc_dly[k] = 0; sc_data[k] = '0;
    end
  endtask

  task automatic random_script(input bit is_in);
    int r;
    for (int k = 0; k < MAX_RETRY; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      sc_kind[k] = R_NONE;
      else if (r < 4)  sc_kind[k] = is_in ? R_DATA : R_ACK;
      else if (r < 7)  sc_kind[k] = R_NAK;
      else             sc_kind[k] = R_ERR;
      sc_dly[k]  = $urandom_range(0, 30);
      sc_data[k] = {$urandom, $urandom};
    end
  endtask

  initial begin
    int d0;
    bit entered;
    bus.txn_start = 1'b0; bus.txn_is_in = 1'b0;
    bus.txn_addr = '0; bus.txn_endp = '0; bus.txn_wdata = '0;
    clear_script();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    // Plain OUT, ACK ten cycles into the receive wait
    clear_script();
    sc_kind[0] = R_ACK; sc_dly[0] = 10;
    run_txn("out_ack", 1'b0, 7'h05, 4'h4, 64'hDEADBEEF_CAFEF00D, 1'b0);

    // OUT: NAK three times, then ACK
    clear_script();
    for (int k = 0; k < 3; k++) begin sc_kind[k] = R_NAK; sc_dly[k] = 3 + k; end
    sc_kind[3] = R_ACK; sc_dly[3] = 7;
    run_txn("out_nak3", 1'b0, 7'h2A, 4'h1, 64'h1122334455667788, 1'b0);

    // OUT: device silent on every attempt
    clear_script();
    run_txn("out_timeout", 1'b0, 7'h11, 4'h9, 64'h0F0F0F0F0F0F0F0F, 1'b0);

    // IN: corrupted first reply, good data second
    clear_script();
    sc_kind[0] = R_ERR; sc_dly[0] = 4;
    sc_kind[1] = R_DATA; sc_dly[1] = 6; sc_data[1] = 64'h0123456789ABCDEF;
    run_txn("in_err_data", 1'b1, 7'h33, 4'h2, '0, 1'b0);

    // Back-pressure: token held waiting for the pipeline for 50 cycles
    clear_script();
    sc_kind[0] = R_DATA; sc_dly[0] = 2; sc_data[0] = 64'hA5A5_5A5A_C3C3_3C3C;
    bp_once = 50;
    run_txn("backpressure", 1'b1, 7'h7F, 4'hF, '0, 1'b0);

    // Reset while waiting for a reply: abandoned with no completion
    clear_script();
    log_q.delete(); att = 0;
    d0 = done_cnt;
    start_txn(1'b1, 7'h44, 4'h6, '0);
    entered = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #2;
      if (rx_act) begin entered = 1; break; end
    end
    check("rst_reached_rx_wait", 128'(entered), 128'(1));
    repeat (5) @(negedge clk);
    #1 rst_L = 1'b0;
    #1 check_reset_outputs("rst_mid");
    busy = 0;
    repeat (5) @(negedge clk);
    #1 rst_L = 1'b1;
    repeat (20) @(negedge clk);
    #2 check("rst_no_done", 128'(done_cnt - d0), 128'(0));
    clear_script();
    sc_kind[0] = R_ACK; sc_dly[0] = 1;
    run_txn("after_reset", 1'b0, 7'h12, 4'h3, 64'hFEEDFACE_00C0FFEE, 1'b0);

    // ACK arriving in the very cycle the timeout fires
    clear_script();
    sc_kind[0] = R_ACK; sc_dly[0] = TIMEOUT - 1;
    run_txn("ack_vs_timeout", 1'b0, 7'h21, 4'h7, 64'h5555AAAA5555AAAA, 1'b0);

    // Start pulsed mid-transaction with different fields must be ignored
    clear_script();
    sc_kind[1] = R_ACK; sc_dly[1] = 5;
    run_txn("ignored_start", 1'b0, 7'h0C, 4'hA, 64'h0BADF00D_12345678, 1'b1);

    // Randomized transactions
    for (int t = 0; t < 16; t++) begin
      bit is_in;
      is_in = 1'($urandom);
      random_script(is_in);
      run_txn($sformatf("rand%0d", t), is_in, 7'($urandom), 4'($urandom),
              {$urandom, $urandom}, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_txn_ctrl.md
Name: usb_txn_ctrl

Overview:
Transaction-level protocol controller above the host packet pipeline. It takes one OUT or IN request from the host-side register interface. It sequences the token, data and handshake packets through the transmit pipeline and interprets the handshake/data results from the receive pipeline. It retries on NAK, CRC error or timeout, then reports a single done/success result upstream.

Parameters:
MAX_RETRY, 8, total attempts per transaction before failure (1..15)
TIMEOUT, 255, receive-wait cycles before an attempt is declared timed out (>=2)

Ports:
clk  in  1  system clock
rst_L  in  1  asynchronous active-low reset
txn_start  in  1  one-cycle request strobe, sampled only in IDLE
txn_is_in  in  1  1 = IN transaction, 0 = OUT transaction
txn_addr  in  7  device address
txn_endp  in  4  endpoint
txn_wdata  in  64  OUT payload
txn_done  out  1  one-cycle completion pulse
txn_success  out  1  result, valid while txn_done=1
txn_rdata  out  64  IN payload, held until next accepted txn_start
out_pid  out  4  PID to transmit pipeline
out_endp  out  4  endpoint to transmit pipeline
out_addr  out  7  address to transmit pipeline
out_data  out  64  data field to transmit pipeline
out_pkttype  out  1  1 = data packet, 0 = token/handshake
out_pktready  out  1  packet request to transmit pipeline
out_down_ready  in  1  transmit pipeline can accept a packet
out_sending  in  1  transmit pipeline is driving the bus
writing  out  1  1 while transmitting; gates the receive pipeline
in_data  in  64  received data payload
in_pktready  in  1  received data packet valid (one cycle)
in_error  in  1  received packet bad (CRC/PID/EOP)
in_ack  in  1  ACK received
in_nak  in  1  NAK received

Behaviour:
- PIDs: OUT=4'b0001, IN=4'b1001, DATA0=4'b0011, ACK=4'b0010, NAK=4'b1010.
- Reset (async, rst_L=0): state IDLE. All outputs 0, including txn_rdata and out_* fields. Retry and timeout counters 0. Reset mid-transaction abandons it with no txn_done.
- States: IDLE, TX_TOK, TX_DATA, RX_WAIT, TX_HS, DONE.
- TX_* send sub-sequence:
  - Drive fields and out_pktready=1 until a cycle with out_down_ready=1. That cycle is the accept; drop out_pktready the next cycle.
  - Hold fields stable.
  - Wait for out_sending to rise, then fall. The fall ends the send.
  - writing=1 from the first TX_* cycle until the cycle after out_sending falls.
- IDLE:
  - txn_start=1 latches addr/endp/wdata/is_in.
  - Clears txn_rdata for the new transaction and sets attempt=1. Goes to TX_TOK.
  - txn_start in any other state is ignored.
- TX_TOK: pid = IN or OUT, pkttype=0, with addr/endp. On end: OUT goes to TX_DATA; IN goes to RX_WAIT.
- TX_DATA: pid=DATA0, pkttype=1, out_data=wdata. On end goes to RX_WAIT.
- RX_WAIT:
  - writing=0. Timeout counter clears on entry and increments each cycle.
  - Priority within one cycle: in_ack > in_nak > in_pktready > in_error > timeout. Timeout fires when count reaches TIMEOUT-1.
  - OUT transaction:
    - in_ack: success, go to DONE.
    - in_nak / in_error / timeout: attempt fails.
    - in_pktready: ignored.
  - IN transaction:
    - in_pktready with in_error=0: latch txn_rdata=in_data, set success flag, go to TX_HS with pid=ACK.
    - in_error: go to TX_HS with pid=NAK, then the attempt fails.
    - in_nak / timeout: attempt fails.
    - in_ack: ignored.
- TX_HS: pkttype=0, pid ACK or NAK. On end: success path goes to DONE; NAK path goes to attempt-fail.
- Attempt fail:
  - If attempt==MAX_RETRY: go to DONE with success=0.
  - Else attempt+1 and go to TX_TOK (the full transaction is repeated, token included).
- DONE: txn_done=1 and txn_success valid for exactly one cycle, then IDLE. txn_done and txn_success are 0 in all other states.
- out_pid/out_pkttype/out_* hold their last values outside TX_* states.
- Attempt counter width: 4 bits. Timeout counter width: clog2(TIMEOUT+1).

Test Plan:
- OUT, addr=7'h05, endp=4'h4, wdata=64'hDEADBEEF_CAFEF00D; bench accepts both packets and replies in_ack 10 cycles after DATA0 ends. Expect: OUT token then DATA0 carrying the payload; txn_done pulse with txn_success=1; writing low only in RX_WAIT.
- OUT with NAK on attempts 1-3 and ACK on attempt 4. Expect: exactly 4 token+DATA0 pairs; success=1.
- OUT with no response ever, TIMEOUT=255, MAX_RETRY=8. Expect: 8 attempts, each RX_WAIT lasting 255 cycles; txn_done with success=0.
- IN; first response in_error, second in_pktready with in_data=64'h0123456789ABCDEF. Expect: NAK sent after attempt 1; ACK sent after attempt 2; txn_rdata=64'h0123456789ABCDEF; success=1.
- Back-pressure and reset: hold out_down_ready=0 for 50 cycles. Expect: out_pktready held with stable fields throughout. Assert rst_L=0 during RX_WAIT: all outputs 0 immediately, no txn_done; a new txn_start after release completes normally.
- Collision and ignored start: in_ack and timeout in the same cycle → ack wins, success=1. txn_start pulsed mid-transaction → ignored; latched addr unchanged.
